// File: rtl/reset_sequencer_if.sv
// Handshake bundle for the reset sequencer: request in,
// sequenced resets and status out.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 3
);
  logic                  req;
  logic [NUM_STAGES-1:0] rst_out;
  logic                  busy;
  logic                  done;

  modport master (
    output req,
    input  rst_out,
    input  busy,
    input  done
  );

  modport slave (
    input  req,
    output rst_out,
    output busy,
    output done
  );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset release: hold all stages, then release them
// one by one (bit 0 first) with a fixed gap between stages.
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             reset,
  reset_sequencer_if.slave bus
);
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ?
                        HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  localparam logic [NUM_STAGES-1:0] ALL_ON = '1;
  localparam logic [NUM_STAGES-1:0] LAST_ON =
    NUM_STAGES'(1) << (NUM_STAGES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  step;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      rst_q   <= ALL_ON;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    step    = 1'b0;

    case (state_q)
      HOLD:    step = (cnt_q == HOLD_LAST);
      RELEASE: step = (cnt_q == GAP_LAST);
      default: step = 1'b0;
    endcase

    if (bus.req) begin
      state_d = HOLD;
      cnt_d   = '0;
      rst_d   = ALL_ON;
      busy_d  = 1'b1;
    end else if (step) begin
      // Shift in a zero: keeps rst_out thermometer-coded
      rst_d = rst_q << 1;
      cnt_d = '0;
      if (rst_q == LAST_ON) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = RELEASE;
      end
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign bus.rst_out = rst_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench: constant vector table, a held-req
// sequence and a randomized run against a timing model.
module tb_reset_sequencer;
  localparam int N = 3;
  localparam int H = 16;
  localparam int G = 4;

  logic clk = 1'b0;
  logic reset;

  reset_sequencer_if #(.NUM_STAGES(N)) bus ();

  reset_sequencer #(
    .NUM_STAGES (N),
    .HOLD_CYCLES(H),
    .GAP_CYCLES (G)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       rs;
    logic       rq;
    logic [2:0] er;
    logic       eb;
    logic       ed;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  // Model: edges since the last trigger edge
  bit m_act = 1'b0;
  int m_e   = 0;

  function automatic logic [N-1:0] m_rst();
    int r;
    if (!m_act) r = N;
    else if (m_e < H) r = 0;
    else begin
      r = 1 + (m_e - H) / G;
      if (r > N) r = N;
    end
    return N'(((1 << N) - 1) & ~((1 << r) - 1));
  endfunction

  function automatic logic m_done();
    return m_act && (m_e == H + (N - 1) * G);
  endfunction

  task automatic step(input logic rs, input logic rq);
    reset   = rs;
    bus.req = rq;
    @(posedge clk);
    #1;
    if (rs || rq) begin
      m_act = 1'b1;
      m_e   = 0;
    end else if (m_act && m_e < 1000000) begin
      m_e++;
    end
  endtask

  task automatic check(input string nm, input logic [N-1:0] er,
                       input logic eb, input logic ed);
    checks++;
    if (bus.rst_out !== er || bus.busy !== eb ||
        bus.done !== ed) begin
      errors++;
      $display("FAIL %s: got rst=%b busy=%b done=%b, need rst=%b busy=%b done=%b",
               nm, bus.rst_out, bus.busy, bus.done, er, eb, ed);
    end
  endtask

  initial begin
    logic [N-1:0] er;
    reset   = 1'b1;
    bus.req = 1'b0;

    // power-up release
    vecs.push_back('{5,  1'b1, 1'b0, 3'b111, 1'b1, 1'b0});
    vecs.push_back('{15, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0});
    vecs.push_back('{1,  1'b0, 1'b0, 3'b110, 1'b1, 1'b0});
    vecs.push_back('{4,  1'b0, 1'b0, 3'b100, 1'b1, 1'b0});
    vecs.push_back('{3,  1'b0, 1'b0, 3'b100, 1'b1, 1'b0});
    vecs.push_back('{1,  1'b0, 1'b0, 3'b000, 1'b0, 1'b1});
    vecs.push_back('{1,  1'b0, 1'b0, 3'b000, 1'b0, 1'b0});
    vecs.push_back('{10, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0});
    // req pulse in IDLE, restart at edge 18
    vecs.push_back('{1,  1'b0, 1'b1, 3'b111, 1'b1, 1'b0});
    vecs.push_back('{18, 1'b0, 1'b0, 3'b110, 1'b1, 1'b0});
    vecs.push_back('{1,  1'b0, 1'b1, 3'b111, 1'b1, 1'b0});
    vecs.push_back('{6,  1'b0, 1'b0, 3'b111, 1'b1, 1'b0});
    vecs.push_back('{10, 1'b0, 1'b0, 3'b110, 1'b1, 1'b0});
    vecs.push_back('{8,  1'b0, 1'b0, 3'b000, 1'b0, 1'b1});
    // req on the last-release edge
    vecs.push_back('{1,  1'b0, 1'b1, 3'b111, 1'b1, 1'b0});
    vecs.push_back('{23, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0});
    vecs.push_back('{1,  1'b0, 1'b1, 3'b111, 1'b1, 1'b0});
    vecs.push_back('{24, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1});
    // reset mid-sequence, then in IDLE
    vecs.push_back('{1,  1'b0, 1'b1, 3'b111, 1'b1, 1'b0});
    vecs.push_back('{22, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0});
    vecs.push_back('{1,  1'b1, 1'b0, 3'b111, 1'b1, 1'b0});
    vecs.push_back('{16, 1'b0, 1'b0, 3'b110, 1'b1, 1'b0});
    vecs.push_back('{8,  1'b0, 1'b0, 3'b000, 1'b0, 1'b1});
    vecs.push_back('{1,  1'b1, 1'b1, 3'b111, 1'b1, 1'b0});
    vecs.push_back('{24, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1});

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].n; c++)
        step(vecs[i].rs, vecs[i].rq);
      check($sformatf("vec%0d", i), vecs[i].er,
            vecs[i].eb, vecs[i].ed);
    end

    // req held for edges 0..9, then released
    for (int e = 0; e <= 9; e++) begin
      step(1'b0, 1'b1);
      check($sformatf("held_e%0d", e), 3'b111, 1'b1, 1'b0);
    end
    for (int e = 10; e <= 35; e++) begin
      step(1'b0, 1'b0);
      if (e < 25)      er = 3'b111;
      else if (e < 29) er = 3'b110;
      else if (e < 33) er = 3'b100;
      else             er = 3'b000;
      check($sformatf("held_e%0d", e), er,
            (e < 33), (e == 33));
    end

    // randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      logic rs, rq;
      rs = ($urandom_range(0, 199) == 0);
      rq = ($urandom_range(0, 39) == 0);
      step(rs, rq);
      check($sformatf("rand_c%0d", c), m_rst(),
            (m_rst() != '0), m_done());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 3: number of sequenced reset outputs; SHALL be >= 1.
REQ-002 Parameter HOLD_CYCLES, default 16: cycles all outputs are held asserted before the first release; SHALL be >= 1.
REQ-003 Parameter GAP_CYCLES, default 4: cycles between consecutive stage releases; SHALL be >= 1.
REQ-004 clk  input  1  single clock; all logic SHALL be rising-edge clk.
REQ-005 reset  input  1  synchronous, active-high reset, sampled only on rising clk.
REQ-006 req  input  1  synchronous reset-sequence request, active-high, sampled each rising edge.
REQ-007 rst_out  output  NUM_STAGES  active-high sequenced resets; bit 0 released first, bit NUM_STAGES-1 last.
REQ-008 busy  output  1  high while any rst_out bit is asserted.
REQ-009 done  output  1  one-cycle pulse on the edge the last stage releases.

Function
REQ-010 All outputs SHALL be registered and driven directly from flops, with no combinational path from any input.
REQ-011 The FSM SHALL have exactly three states: HOLD (all stages asserted, counting HOLD_CYCLES), RELEASE (stages releasing, counting GAP_CYCLES per stage), and IDLE (all released).
REQ-012 "Trigger edge" is a rising edge that samples reset=1 or req=1; every trigger edge SHALL set rst_out to all ones, busy=1, done=0, state=HOLD, and the counter to 0.
REQ-013 rst_out[0] SHALL deassert exactly HOLD_CYCLES edges after the last trigger edge, with the FSM entering RELEASE on that edge.
REQ-014 rst_out[k], for k>=1, SHALL deassert exactly GAP_CYCLES edges after rst_out[k-1] deasserted.
REQ-015 On the edge rst_out[NUM_STAGES-1] deasserts, the block SHALL set done=1 and busy=0 and enter IDLE; done SHALL return to 0 on the next edge.
REQ-016 rst_out SHALL always be thermometer-coded: rst_out[k]=1 implies rst_out[j]=1 for all j>k.
REQ-017 With NUM_STAGES=1, the block SHALL release the single stage and pulse done at edge HOLD_CYCLES; GAP_CYCLES SHALL then be unused.
REQ-018 A req in HOLD or RELEASE SHALL restart the sequence per REQ-012; stages already released SHALL be reasserted on that edge.
REQ-019 A req sampled on the edge that would release the last stage SHALL take priority: no done pulse, and rst_out SHALL be all ones.
REQ-020 req held high SHALL keep rst_out all ones; release timing SHALL count from the last edge sampling req=1.
REQ-021 In IDLE with req=0, all outputs SHALL hold: rst_out=0, busy=0, done=0.
REQ-022 The counter width SHALL be ceil(log2(max(HOLD_CYCLES,GAP_CYCLES)+1)) bits, and the counter SHALL never wrap during a sequence.

Reset
REQ-023 While reset is sampled high, the block SHALL drive rst_out all ones, busy=1, done=0, and state HOLD, regardless of req.
REQ-024 Deasserting reset SHALL start the sequence automatically (power-up release), with no req required.
REQ-025 Reset asserted mid-sequence (HOLD or RELEASE) or in IDLE SHALL take effect on the next rising edge per REQ-023, and no done pulse SHALL occur.

Verification (defaults NUM_STAGES=3, HOLD_CYCLES=16, GAP_CYCLES=4; edge 0 = last trigger edge)
REQ-026 Reset high for 5 cycles, then low -> rst_out=111 through edge 15; 110 at edge 16; 100 at edge 20; 000 at edge 24 with done=1 for one cycle and busy=0 from edge 24.
REQ-027 In IDLE, a 1-cycle req pulse at edge 0 -> rst_out=111 at edge 0; releases at edges 16/20/24; done at edge 24 only.
REQ-028 Sequence started at edge 0, req pulse at edge 18 (rst_out=110) -> rst_out=111 at edge 18; releases at edges 34/38/42; no done at edge 24; done at edge 42.
REQ-029 req sampled at edge 24 of a sequence -> rst_out=111 at edge 24, done stays 0; next done at edge 48.
REQ-030 req held high for edges 0-9 -> rst_out=111 throughout; releases at edges 25/29/33, relative to edge 9.
REQ-031 Reset asserted at edge 22 (rst_out=100) -> rst_out=111, busy=1, done=0 at edge 22; the sequence restarts when reset is deasserted.
